// File: rtl/updown_sweep_ctrl.sv
// updown_sweep_ctrl: drives a 5-bit up/down counter through triangular sweeps
// between latched bounds lo and hi, for a programmed number of repeats or
// free-running until abort. mode follows the up/down convention 0 = up, 1 = down.
// Optional build macro: SWEEP_DWELL_EN adds a one-cycle dwell at each peak
// (q = hi, mode = 0) and at each intermediate trough (q = lo, mode = 1).
module updown_sweep_ctrl #(
  parameter int WIDTH  = 5,
  parameter int REPS_W = 4
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic              abort,
  input  logic [WIDTH-1:0]  lo,
  input  logic [WIDTH-1:0]  hi,
  input  logic [REPS_W-1:0] reps,
  output logic [WIDTH-1:0]  q,
  output logic              mode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_UP       = 3'd1,
    S_DOWN     = 3'd2,
    S_DWELL_HI = 3'd3,
    S_DWELL_LO = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    q_q, q_d;
  logic [WIDTH-1:0]    lo_q, lo_d;
  logic [WIDTH-1:0]    hi_q, hi_d;
  logic [REPS_W-1:0]   reps_q, reps_d;
  logic [REPS_W-1:0]   cnt_q, cnt_d;
  logic                mode_q, mode_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  // Sweep count after the sweep that is finishing now; saturates so that a
  // free-running program never wraps the counter.
  logic [REPS_W-1:0]   cnt_inc;
  logic                last_sweep;

  assign cnt_inc    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  // reps of zero means free-run, so it never matches as the final sweep
  assign last_sweep = (reps_q != '0) && (cnt_inc == reps_q);

  // Next-state, next-count and registered-output computation
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE does nothing except suppress a simultaneous start
        if (start && !abort) begin
          lo_d   = lo;
          hi_d   = hi;
          reps_d = reps;
          if (lo >= hi) begin
            err_d = 1'b1;
          end else begin
            q_d     = lo;
            cnt_d   = '0;
            state_d = S_UP;
          end
        end
      end

      S_UP: begin
        if (q_q != hi_q) begin
          q_d = q_q + 1'b1;
        end else begin
`ifdef SWEEP_DWELL_EN
          // hold the peak value for one more cycle
          state_d = S_DWELL_HI;
`else
          q_d     = hi_q - 1'b1;
          state_d = S_DOWN;
`endif
        end
      end

`ifdef SWEEP_DWELL_EN
      S_DWELL_HI: begin
        q_d     = hi_q - 1'b1;
        state_d = S_DOWN;
      end

      S_DWELL_LO: begin
        q_d     = lo_q + 1'b1;
        state_d = S_UP;
      end
`endif

      S_DOWN: begin
        if (q_q != lo_q) begin
          q_d = q_q - 1'b1;
        end else begin
          // sweep complete: the lo cycle is shared with the next sweep
          cnt_d = cnt_inc;
          if (last_sweep) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
`ifdef SWEEP_DWELL_EN
            state_d = S_DWELL_LO;
`else
            q_d     = lo_q + 1'b1;
            state_d = S_UP;
`endif
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // abort from any busy state freezes q and returns to IDLE silently
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      q_d     = q_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end

    // direction and busy are derived from the next state so they are
    // registered alongside it
    mode_d = (state_d == S_DOWN) || (state_d == S_DWELL_LO);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low clear
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      reps_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      reps_q  <= reps_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign q    = q_q;
  assign mode = mode_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Testbench for updown_sweep_ctrl. Stimulus pushes the expected post-edge
// outputs into a scoreboard queue; a monitor pops and compares one entry
// after every rising edge. Honours SWEEP_DWELL_EN when building expectations.
module tb_updown_sweep_ctrl;

  typedef struct {
    logic [4:0] q;
    logic       mode;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  logic       clk;
  logic       clr;
  logic       start;
  logic       abort;
  logic [4:0] lo;
  logic [4:0] hi;
  logic [3:0] reps;
  logic [4:0] q;
  logic       mode;
  logic       busy;
  logic       done;
  logic       err;

  exp_t  sb_q[$];
  string tag_q[$];
  exp_t  plan[$];
  exp_t  mon_e;
  string mon_t;
  int    n_cmp;
  int    n_bad;
  int    cur_q;

  updown_sweep_ctrl #(.WIDTH(5), .REPS_W(4)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .abort (abort),
    .lo    (lo),
    .hi    (hi),
    .reps  (reps),
    .q     (q),
    .mode  (mode),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int qv, input bit m, input bit b, input bit d, input bit e);
    exp_t r;
    r.q    = 5'(qv);
    r.mode = m;
    r.busy = b;
    r.done = d;
    r.err  = e;
    return r;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge
  task automatic cyc(input bit s, input bit a, input bit c, input logic [4:0] l,
                     input logic [4:0] h, input logic [3:0] r, input exp_t e, input string tag);
    @(negedge clk);
    start = s;
    abort = a;
    clr   = c;
    lo    = l;
    hi    = h;
    reps  = r;
    sb_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 4'd0, mk(cur_q, 0, 0, 0, 0), tag);
  endtask

  // Expected triangular waveform, one entry per cycle starting with the
  // cycle after the start edge
  task automatic build(input int l, input int h, input int r, input int nsw);
    int n;
    plan.delete();
    n = (r == 0) ? nsw : r;
    for (int s = 0; s < n; s++) begin
      for (int v = (s == 0) ? l : l + 1; v <= h; v++) plan.push_back(mk(v, 0, 1, 0, 0));
`ifdef SWEEP_DWELL_EN
      plan.push_back(mk(h, 0, 1, 0, 0));
`endif
      for (int v = h - 1; v >= l; v--) plan.push_back(mk(v, 1, 1, 0, 0));
`ifdef SWEEP_DWELL_EN
      if (s != n - 1) plan.push_back(mk(l, 1, 1, 0, 0));
`endif
    end
    if (r != 0) plan.push_back(mk(l, 0, 0, 1, 0));
  endtask

  // Run one program; ign = cycle index of an extra start pulse while busy,
  // abt/rst = index of the cycle before whose edge abort/clear is applied
  task automatic run_prog(input int l, input int h, input int r, input int nsw,
                          input int ign, input int abt, input int rst, input string name);
    build(l, h, r, nsw);
    $display("[%0t] program %s: lo=%0d hi=%0d reps=%0d cycles=%0d", $time, name, l, h, r, plan.size());
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abt) begin
        cyc(1'b0, 1'b1, 1'b1, 5'($urandom), 5'($urandom), 4'($urandom),
            mk(cur_q, 0, 0, 0, 0), {name, "/abort"});
        return;
      end
      if (i == rst) begin
        cyc(1'b0, 1'b0, 1'b0, 5'($urandom), 5'($urandom), 4'($urandom),
            mk(0, 0, 0, 0, 0), {name, "/clr"});
        cur_q = 0;
        return;
      end
      if (i == 0)
        cyc(1'b1, 1'b0, 1'b1, 5'(l), 5'(h), 4'(r), plan[i], name);
      else
        cyc(i == ign, 1'b0, 1'b1, 5'($urandom), 5'($urandom), 4'($urandom), plan[i], name);
      cur_q = int'(plan[i].q);
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        mon_t = tag_q.pop_front();
        n_cmp++;
        if (q !== mon_e.q || mode !== mon_e.mode || busy !== mon_e.busy ||
            done !== mon_e.done || err !== mon_e.err) begin
          n_bad++;
          $display("FAIL %s at %0t: got q=%0d mode=%b busy=%b done=%b err=%b, expected q=%0d mode=%b busy=%b done=%b err=%b",
                   mon_t, $time, q, mode, busy, done, err,
                   mon_e.q, mon_e.mode, mon_e.busy, mon_e.done, mon_e.err);
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cur_q = 0;
    clr   = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    lo    = '0;
    hi    = '0;
    reps  = '0;

    // reset held two cycles
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0, mk(0, 0, 0, 0, 0), "reset");
    cyc(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 4'd0, mk(0, 0, 0, 0, 0), "reset");
    idle("post_reset");
    idle("post_reset");

    // single sweep, then a new program started in the done cycle
    run_prog(3, 6, 1, 0, -1, -1, -1, "single");
    run_prog(0, 31, 2, 0, -1, -1, -1, "full_range");
    idle("after_full");

    // rejected starts: equal and inverted bounds
    $display("[%0t] program reject: lo=9 hi=9", $time);
    cyc(1'b1, 1'b0, 1'b1, 5'd9, 5'd9, 4'd1, mk(cur_q, 0, 0, 0, 1), "reject_eq");
    idle("reject_eq_after");
    $display("[%0t] program reject: lo=10 hi=4", $time);
    cyc(1'b1, 1'b0, 1'b1, 5'd10, 5'd4, 4'd2, mk(cur_q, 0, 0, 0, 1), "reject_inv");
    idle("reject_inv_after");

    // start together with abort in IDLE does nothing
    $display("[%0t] program start+abort in idle: lo=1 hi=8", $time);
    cyc(1'b1, 1'b1, 1'b1, 5'd1, 5'd8, 4'd1, mk(cur_q, 0, 0, 0, 0), "start_abort");
    idle("start_abort_after");

    // free-run aborted at q=4 on the way down, with an ignored start
    run_prog(2, 5, 0, 3, 2, 5, -1, "freerun_abort");
    idle("abort_hold");
    idle("abort_hold");

    // maximum repeat count with the narrowest legal range
    run_prog(0, 1, 15, 0, -1, -1, -1, "reps15");
    // free-run past the sweep-counter saturation point
    run_prog(0, 1, 0, 20, -1, 38, -1, "freerun_sat");
    idle("sat_hold");

    // top-of-range single sweep
    run_prog(30, 31, 1, 0, -1, -1, -1, "top");
    idle("top_hold");

    // clear asserted mid-sweep
    run_prog(7, 20, 1, 0, 4, -1, 10, "clr_mid");
    idle("clr_hold");
    idle("clr_hold");

    // drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
